// File: rtl/exe_md_stage.sv
// Execute stage: ALU, multiplier, iterative restoring divider, store lane alignment.
// Optional macro EXE_STALL_CNT_EN adds a saturating stall_cnt output.
module exe_md_stage #(
    parameter  int unsigned XLEN      = 32,
    parameter  int unsigned PAYLOAD_W = 64,
    localparam int unsigned LANES     = XLEN / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_allow,
    input  logic [4:0]           in_op,
    input  logic [XLEN-1:0]      in_src1,
    input  logic [XLEN-1:0]      in_src2,
    input  logic [XLEN-1:0]      in_st_data,
    input  logic                 in_mem_en,
    input  logic                 in_mem_we,
    input  logic [1:0]           in_mem_size,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_allow,
    output logic [XLEN-1:0]      out_result,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_ale,
    output logic                 out_busy,
    output logic                 data_ram_en,
    output logic [XLEN-1:0]      data_ram_addr,
    output logic [LANES-1:0]     data_ram_w_en,
    output logic [XLEN-1:0]      data_ram_w_data
`ifdef EXE_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int unsigned SHW   = $clog2(XLEN);
    localparam int unsigned LW    = $clog2(LANES);
    localparam int unsigned CNT_W = SHW;

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLT   = 5'd2,  OP_SLTU = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR   = 5'd6,  OP_NOR  = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA   = 5'd10, OP_LUI  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd12, OP_MULH = 5'd13, OP_MULHU = 5'd14, OP_DIV  = 5'd15;
    localparam logic [4:0] OP_DIVU = 5'd16, OP_MOD  = 5'd17, OP_MODU  = 5'd18;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

    logic                 r_valid;
    logic [4:0]           r_op;
    logic [XLEN-1:0]      r_src1, r_src2, r_st_data;
    logic                 r_mem_en, r_mem_we;
    logic [1:0]           r_mem_size;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [1:0]           r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [XLEN-1:0]      r_quot, r_rem, r_dvsr;

    logic                 w_load, w_in_div, w_in_signed, w_in_neg1, w_in_neg2;
    logic [XLEN-1:0]      w_in_mag1, w_in_mag2;
    logic                 w_is_div, w_ready_go, w_signed, w_s1, w_s2, w_dz, w_ge;
    logic [XLEN:0]        w_rem_sh, w_diff;
    logic [XLEN-1:0]      w_rem_step, w_quot_step, w_rem_fix, w_quot_fix;
    logic [2*XLEN-1:0]    w_prod;
    logic [XLEN-1:0]      w_mulh, w_result;
    logic [SHW-1:0]       w_shamt;
    logic [LANES-1:0]     w_size_mask;
    logic [2:0]           w_low_mask;
    logic                 w_ale, w_store;
    logic [LW-1:0]        w_lane_off;
    logic [XLEN-1:0]      w_st_keep;

    // Handshake
    assign w_is_div   = (r_op >= OP_DIV) && (r_op <= OP_MODU);
    assign w_ready_go = ~w_is_div | (r_state == S_DONE);
    assign in_allow   = ~r_valid | (w_ready_go & out_allow);
    assign w_load     = in_valid & in_allow & ~flush;
    assign out_valid  = r_valid & w_ready_go & ~flush;
    assign out_busy   = (r_state == S_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_op       <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_st_data  <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_size <= '0;
            r_payload  <= '0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (in_allow)
                r_valid <= in_valid;
            if (w_load) begin
                r_op       <= in_op;
                r_src1     <= in_src1;
                r_src2     <= in_src2;
                r_st_data  <= in_st_data;
                r_mem_en   <= in_mem_en;
                r_mem_we   <= in_mem_we;
                r_mem_size <= in_mem_size;
                r_payload  <= in_payload;
            end
        end
    end

    // Divider operand magnitudes captured at load
    assign w_in_div    = (in_op >= OP_DIV) && (in_op <= OP_MODU);
    assign w_in_signed = (in_op == OP_DIV) || (in_op == OP_MOD);
    assign w_in_neg1   = w_in_signed & in_src1[XLEN-1];
    assign w_in_neg2   = w_in_signed & in_src2[XLEN-1];
    assign w_in_mag1   = w_in_neg1 ? -in_src1 : in_src1;
    assign w_in_mag2   = w_in_neg2 ? -in_src2 : in_src2;

    // One restoring step; the dividend shifts out of r_quot as quotient bits shift in
    assign w_rem_sh    = {r_rem, r_quot[XLEN-1]};
    assign w_diff      = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge        = ~w_diff[XLEN];
    assign w_rem_step  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quot_step = {r_quot[XLEN-2:0], w_ge};

    assign w_signed   = (r_op == OP_DIV) || (r_op == OP_MOD);
    assign w_s1       = w_signed & r_src1[XLEN-1];
    assign w_s2       = w_signed & r_src2[XLEN-1];
    assign w_dz       = (r_src2 == '0);
    assign w_quot_fix = w_dz ? '1 : ((w_s1 ^ w_s2) ? -w_quot_step : w_quot_step);
    assign w_rem_fix  = w_dz ? r_src1 : (w_s1 ? -w_rem_step : w_rem_step);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush)
            w_state_nxt = S_IDLE;
        else if (w_load && w_in_div)
            w_state_nxt = S_RUN;
        else begin
            case (r_state)
                S_RUN:   if (r_cnt == '0) w_state_nxt = S_DONE;
                S_DONE:  if (out_allow) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
        end else if (w_load && w_in_div) begin
            r_cnt  <= CNT_W'(XLEN - 1);
            r_quot <= w_in_mag1;
            r_rem  <= '0;
            r_dvsr <= w_in_mag2;
        end else if (r_state == S_RUN && !flush) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
                r_quot <= w_quot_fix;
                r_rem  <= w_rem_fix;
            end else begin
                r_quot <= w_quot_step;
                r_rem  <= w_rem_step;
            end
        end
    end

    // Signed high product derived from the single unsigned multiply
    assign w_prod  = {{XLEN{1'b0}}, r_src1} * {{XLEN{1'b0}}, r_src2};
    assign w_mulh  = w_prod[2*XLEN-1:XLEN] - (r_src1[XLEN-1] ? r_src2 : '0)
                                           - (r_src2[XLEN-1] ? r_src1 : '0);
    assign w_shamt = r_src2[SHW-1:0];

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_ADD:   w_result = r_src1 + r_src2;
            OP_SUB:   w_result = r_src1 - r_src2;
            OP_SLT:   w_result = XLEN'($signed(r_src1) < $signed(r_src2));
            OP_SLTU:  w_result = XLEN'(r_src1 < r_src2);
            OP_AND:   w_result = r_src1 & r_src2;
            OP_OR:    w_result = r_src1 | r_src2;
            OP_XOR:   w_result = r_src1 ^ r_src2;
            OP_NOR:   w_result = ~(r_src1 | r_src2);
            OP_SLL:   w_result = r_src1 << w_shamt;
            OP_SRL:   w_result = r_src1 >> w_shamt;
            OP_SRA:   w_result = $unsigned($signed(r_src1) >>> w_shamt);
            OP_LUI:   w_result = r_src2;
            OP_MUL:   w_result = w_prod[XLEN-1:0];
            OP_MULH:  w_result = w_mulh;
            OP_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: w_result = r_quot;
            OP_MOD, OP_MODU: w_result = r_rem;
            default:  w_result = '0;
        endcase
    end

    assign out_result    = w_result;
    assign out_payload   = r_payload;
    assign data_ram_addr = w_result;

    // Access size as lane mask and as address bits that must be zero
    always_comb begin
        w_size_mask = '0;
        w_low_mask  = 3'b000;
        case (r_mem_size)
            2'd0:    begin w_size_mask = LANES'(1);     w_low_mask = 3'b000; end
            2'd1:    begin w_size_mask = LANES'(3);     w_low_mask = 3'b001; end
            2'd2:    begin w_size_mask = LANES'(15);    w_low_mask = 3'b011; end
            default: begin w_size_mask = LANES'(8'hFF); w_low_mask = 3'b111; end
        endcase
    end

    always_comb begin
        w_st_keep = '0;
        for (int i = 0; i < int'(LANES); i++)
            w_st_keep[8*i +: 8] = w_size_mask[i] ? r_st_data[8*i +: 8] : 8'h00;
    end

    assign w_lane_off      = w_result[LW-1:0];
    assign w_ale           = r_valid & r_mem_en & (|(w_result[2:0] & w_low_mask));
    assign w_store         = r_valid & r_mem_en & r_mem_we & ~w_ale;
    assign out_ale         = w_ale;
    assign data_ram_en     = r_valid & r_mem_en & ~w_ale & w_ready_go & out_allow & ~flush;
    assign data_ram_w_en   = w_store ? (w_size_mask << w_lane_off) : '0;
    assign data_ram_w_data = w_store ? (w_st_keep << {w_lane_off, 3'b000}) : '0;

`ifdef EXE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (r_valid && !(w_ready_go && out_allow) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_exe_md_stage.sv
// Bench for exe_md_stage: vector table, directed multi-cycle sequences and a random
// phase against an arithmetic reference model.
module tb_exe_md_stage;

    logic        clk, reset, flush, in_valid, in_allow;
    logic [4:0]  in_op;
    logic [31:0] in_src1, in_src2, in_st_data;
    logic        in_mem_en, in_mem_we;
    logic [1:0]  in_mem_size;
    logic [63:0] in_payload;
    logic        out_valid, out_allow;
    logic [31:0] out_result;
    logic [63:0] out_payload;
    logic        out_ale, out_busy, data_ram_en;
    logic [31:0] data_ram_addr, data_ram_w_data;
    logic [3:0]  data_ram_w_en;
`ifdef EXE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    exe_md_stage #(.XLEN(32), .PAYLOAD_W(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_allow(in_allow), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_st_data(in_st_data),
        .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_mem_size(in_mem_size),
        .in_payload(in_payload), .out_valid(out_valid), .out_allow(out_allow),
        .out_result(out_result), .out_payload(out_payload), .out_ale(out_ale),
        .out_busy(out_busy), .data_ram_en(data_ram_en), .data_ram_addr(data_ram_addr),
        .data_ram_w_en(data_ram_w_en), .data_ram_w_data(data_ram_w_data)
`ifdef EXE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_div(input logic [4:0] op);
        return (op >= 5'd15) && (op <= 5'd18);
    endfunction

    // Reference: plain integer arithmetic with the architectural divide corner cases
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int          sa, sb;
        logic [63:0] sp, up;
        bit          ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        sp  = 64'(longint'(sa) * longint'(sb));
        up  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return {31'd0, sa < sb};
            5'd3:  return {31'd0, a < b};
            5'd4:  return a & b;
            5'd5:  return a | b;
            5'd6:  return a ^ b;
            5'd7:  return ~(a | b);
            5'd8:  return a << b[4:0];
            5'd9:  return a >> b[4:0];
            5'd10: return 32'(sa >>> b[4:0]);
            5'd11: return b;
            5'd12: return sp[31:0];
            5'd13: return sp[63:32];
            5'd14: return up[63:32];
            5'd15: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            5'd16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd17: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            5'd18: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_valid(output int busy_n, output bit got, output bit allow_low);
        busy_n    = 0;
        got       = 1'b0;
        allow_low = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            #2;
            if (out_valid) got = 1'b1;
            else begin
                if (out_busy) busy_n++;
                if (in_allow) allow_low = 1'b0;
                step();
            end
        end
    endtask

    // Issue one non-memory op and check its result, payload and divide timing
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int busy_n;
        bit got, allow_low;
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        in_mem_en = 1'b0; in_mem_we = 1'b0; in_payload = {a, b}; out_allow = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(busy_n, got, allow_low);
        chk({nm, " valid"}, 64'(got), 64'd1);
        chk({nm, " result"}, 64'(out_result), 64'(exp));
        chk({nm, " payload"}, out_payload, {a, b});
        if (is_div(op)) begin
            chk({nm, " busy cycles"}, 64'(busy_n), 64'd32);
            chk({nm, " in_allow low"}, 64'(allow_low), 64'd1);
        end
        step();
    endtask

    initial begin
        vec_t vecs[$];
        int   busy_n, cnt;
        bit   got, allow_low;
        logic [4:0]  rop;
        logic [31:0] ra, rb;
`ifdef EXE_STALL_CNT_EN
        logic [31:0] stall0;
`endif

        vecs.push_back('{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});
        vecs.push_back('{5'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE});
        vecs.push_back('{5'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
        vecs.push_back('{5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
        vecs.push_back('{5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0});
        vecs.push_back('{5'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0});
        vecs.push_back('{5'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F});
        vecs.push_back('{5'd8,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002});
        vecs.push_back('{5'd9,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000});
        vecs.push_back('{5'd10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000});
        vecs.push_back('{5'd11, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000});
        vecs.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{5'd13, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF});
        vecs.push_back('{5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{5'd15, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
        vecs.push_back('{5'd17, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{5'd16, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{5'd18, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005});
        vecs.push_back('{5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{5'd15, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{5'd17, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9});
        vecs.push_back('{5'd16, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E});
        vecs.push_back('{5'd20, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
        in_st_data = '0; in_mem_en = 1'b0; in_mem_we = 1'b0; in_mem_size = '0;
        in_payload = '0; out_allow = 1'b1;
        #12;
        chk("rst in_allow", 64'(in_allow), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_busy", 64'(out_busy), 64'd0);
        chk("rst ram_en", 64'(data_ram_en), 64'd0);
        chk("rst w_en", 64'(data_ram_w_en), 64'd0);
        chk("rst ale", 64'(out_ale), 64'd0);
        step();
        reset = 1'b1;
        step();

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                                 $sformatf("vec%0d", i));

        // Byte store lands in the top lane
        in_valid = 1'b1; in_op = 5'd0; in_src1 = 32'h1000; in_src2 = 32'd3;
        in_mem_en = 1'b1; in_mem_we = 1'b1; in_mem_size = 2'd0; in_st_data = 32'h0000_00AB;
        step();
        in_valid = 1'b0;
        #2;
        chk("sb addr", 64'(data_ram_addr), 64'h1003);
        chk("sb en", 64'(data_ram_en), 64'd1);
        chk("sb w_en", 64'(data_ram_w_en), 64'b1000);
        chk("sb w_data", 64'(data_ram_w_data), 64'hAB00_0000);
        chk("sb ale", 64'(out_ale), 64'd0);
        step();

        // Misaligned half store raises ale and suppresses the request
        in_valid = 1'b1; in_src1 = 32'h1000; in_src2 = 32'd1; in_mem_size = 2'd1;
        in_st_data = 32'h0000_1234;
        step();
        in_valid = 1'b0;
        #2;
        chk("sh mis ale", 64'(out_ale), 64'd1);
        chk("sh mis en", 64'(data_ram_en), 64'd0);
        chk("sh mis w_en", 64'(data_ram_w_en), 64'd0);
        chk("sh mis valid", 64'(out_valid), 64'd1);
        step();

        // Aligned half store in the upper lanes
        in_valid = 1'b1; in_src1 = 32'h1000; in_src2 = 32'd2; in_st_data = 32'hBEEF_1234;
        step();
        in_valid = 1'b0;
        #2;
        chk("sh w_en", 64'(data_ram_w_en), 64'b1100);
        chk("sh w_data", 64'(data_ram_w_data), 64'h1234_0000);
        chk("sh en", 64'(data_ram_en), 64'd1);
        step();

        // Word store held by back-pressure: exactly one request, on release
        in_valid = 1'b1; in_src1 = 32'h2000; in_src2 = 32'd4; in_mem_size = 2'd2;
        in_st_data = 32'hCAFE_F00D;
        step();
        in_valid = 1'b0; out_allow = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            if (data_ram_en) cnt++;
            chk("sw hold valid", 64'(out_valid), 64'd1);
            chk("sw hold in_allow", 64'(in_allow), 64'd0);
            step();
        end
        chk("sw no early req", 64'(cnt), 64'd0);
        out_allow = 1'b1;
        #2;
        chk("sw release en", 64'(data_ram_en), 64'd1);
        chk("sw w_en", 64'(data_ram_w_en), 64'hF);
        chk("sw w_data", 64'(data_ram_w_data), 64'hCAFE_F00D);
        step();
        #2;
        chk("sw after en", 64'(data_ram_en), 64'd0);
        chk("sw after valid", 64'(out_valid), 64'd0);
        step();
        in_mem_en = 1'b0; in_mem_we = 1'b0;

        // Flush in RUN cycle 10, then an ADD; no divide result may ever appear
`ifdef EXE_STALL_CNT_EN
        stall0 = stall_cnt;
`endif
        in_valid = 1'b1; in_op = 5'd15; in_src1 = 32'd100; in_src2 = 32'd7;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        #2;
        chk("fl busy", 64'(out_busy), 64'd1);
        chk("fl out_valid", 64'(out_valid), 64'd0);
        chk("fl ram_en", 64'(data_ram_en), 64'd0);
        step();
        flush = 1'b0;
        #2;
        chk("fl idle busy", 64'(out_busy), 64'd0);
        chk("fl in_allow", 64'(in_allow), 64'd1);
`ifdef EXE_STALL_CNT_EN
        chk("fl stall_cnt", 64'(stall_cnt - stall0), 64'd10);
`endif
        in_valid = 1'b1; in_op = 5'd0; in_src1 = 32'd2; in_src2 = 32'd3;
        step();
        in_valid = 1'b0;
        #2;
        chk("fl add valid", 64'(out_valid), 64'd1);
        chk("fl add result", 64'(out_result), 64'd5);
        step();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (out_valid) cnt++;
            step();
        end
        chk("fl no div result", 64'(cnt), 64'd0);

        // Flush drops the held op and blocks the op presented alongside it
        in_valid = 1'b1; in_op = 5'd0; in_src1 = 32'd1; in_src2 = 32'd1; out_allow = 1'b0;
        step();
        in_src1 = 32'd9; in_src2 = 32'd9; out_allow = 1'b1; flush = 1'b1;
        #2;
        chk("fl2 out_valid", 64'(out_valid), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #2;
        chk("fl2 not loaded", 64'(out_valid), 64'd0);
        step();

        // Divide held in DONE, then a second divide loaded on the handoff edge
        in_valid = 1'b1; in_op = 5'd16; in_src1 = 32'd100; in_src2 = 32'd7; out_allow = 1'b0;
        step();
        in_valid = 1'b0;
        wait_valid(busy_n, got, allow_low);
        chk("bp div valid", 64'(got), 64'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            #2;
            chk("bp done result", 64'(out_result), 64'd14);
            chk("bp done busy", 64'(out_busy), 64'd0);
            chk("bp done in_allow", 64'(in_allow), 64'd0);
        end
        out_allow = 1'b1; in_valid = 1'b1; in_src1 = 32'd50; in_src2 = 32'd5;
        #1;
        chk("b2b in_allow", 64'(in_allow), 64'd1);
        step();
        in_valid = 1'b0;
        wait_valid(busy_n, got, allow_low);
        chk("b2b valid", 64'(got), 64'd1);
        chk("b2b busy cycles", 64'(busy_n), 64'd32);
        chk("b2b result", 64'(out_result), 64'd10);
        step();

        for (int i = 0; i < 30; i++) begin
            rop = 5'($urandom_range(0, 20));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(rop, ra, rb, ref_result(rop, ra, rb), $sformatf("rnd%0d op%0d", i, rop));
        end

        // Asynchronous reset in the middle of a divide
        in_valid = 1'b1; in_op = 5'd15; in_src1 = 32'd1000; in_src2 = 32'd3;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        reset = 1'b0;
        #1;
        chk("mid rst busy", 64'(out_busy), 64'd0);
        chk("mid rst valid", 64'(out_valid), 64'd0);
        chk("mid rst in_allow", 64'(in_allow), 64'd1);
        step();
        reset = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
